// File: rtl/mem_arbiter.sv
// Two-requester (cpu/ext) arbiter in front of a synchronous-read byte memory.
// Supports round-robin or cpu-priority arbitration with an ext starvation guard.
module mem_arbiter #(
    parameter int AW         = 8,
    parameter int STARVE_MAX = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prio_mode,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [7:0]    ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [7:0]    ext_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, LAST_CPU, LAST_EXT} owner_t;

    owner_t        state;
    logic [CW-1:0] starve_cnt;
    logic          cpu_rd_q;
    logic          ext_rd_q;
    logic          starved;

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && ext_req) begin
                if (prio_mode)
                    ext_gnt = starved;
                else
                    ext_gnt = (state == LAST_CPU);
                cpu_gnt = !ext_gnt;
            end else begin
                cpu_gnt = cpu_req;
                ext_gnt = ext_req;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            cpu_rd_q   <= 1'b0;
            ext_rd_q   <= 1'b0;
        end else begin
            if (cpu_gnt)
                state <= LAST_CPU;
            else if (ext_gnt)
                state <= LAST_EXT;

            if (ext_req && !ext_gnt) begin
                if (!starved)
                    starve_cnt <= starve_cnt + CW'(1);
            end else begin
                starve_cnt <= '0;
            end

            cpu_rd_q <= cpu_gnt && !cpu_we;
            ext_rd_q <= ext_gnt && !ext_we;
        end
    end

    // Masking with reset drops a read that was granted just before reset rose.
    assign cpu_rvalid = cpu_rd_q && !reset;
    assign ext_rvalid = ext_rd_q && !reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : 8'h00;
    assign ext_rdata  = ext_rvalid ? mem_rdata : 8'h00;

endmodule
